// File: rtl/cic_decimator_pkg.sv
// Shared CIC decimator constants: default order/ratio and the word-width formula,
// so downstream readout logic can size its input from the same source.
package cic_decimator_pkg;

  localparam int DEFAULT_ORDER = 3;
  localparam int DEFAULT_DECIM = 64;

  // Bit growth of an N-stage, ratio-R CIC with a 1-bit unsigned input.
  function automatic int out_width(input int order, input int decim);
    return order * $clog2(decim) + 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x_delayed, evaluated only when the upstream valid is set.
module cic_comb_stage #(
  parameter int WIDTH = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_x,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_y
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] dly_q, dly_d;
  logic             valid_q, valid_d;

  always_comb begin
    y_d     = y_q;
    dly_d   = dly_q;
    valid_d = i_valid;
    if (i_valid) begin
      y_d   = i_x - dly_q;
      dly_d = i_x;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      y_q     <= '0;
      dly_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      dly_q   <= dly_d;
      valid_q <= valid_d;
    end
  end

  assign o_y     = y_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/cic_decimator.sv
// Decimating CIC filter for a 1-bit sigma-delta bitstream: ORDER integrators at the
// enabled input rate, decimate by DECIM, then ORDER comb sections on the system clock.
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int  ORDER     = DEFAULT_ORDER,
  parameter int  DECIM     = DEFAULT_DECIM,
  localparam int OUT_WIDTH = out_width(ORDER, DECIM)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_d,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid
);

  localparam int CNT_W = $clog2(DECIM);

  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [ORDER-1:0][OUT_WIDTH-1:0]  int_q, int_d;
  logic [OUT_WIDTH-1:0]             comb_x_q, comb_x_d;
  logic                             comb_v_q, comb_v_d;
  logic                             strobe;

  // Integrators wrap modulo 2^OUT_WIDTH on purpose; the comb differences undo the wrap.
  always_comb begin
    cnt_d    = cnt_q;
    int_d    = int_q;
    strobe   = i_en && (cnt_q == CNT_W'(DECIM - 1));
    if (i_en) begin
      cnt_d    = cnt_q + 1'b1;
      int_d[0] = int_q[0] + OUT_WIDTH'(i_d);
      for (int k = 1; k < ORDER; k++) begin
        int_d[k] = int_q[k] + int_q[k-1];
      end
    end
    comb_x_d = strobe ? int_d[ORDER-1] : comb_x_q;
    comb_v_d = strobe;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q    <= '0;
      int_q    <= '0;
      comb_x_q <= '0;
      comb_v_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      int_q    <= int_d;
      comb_x_q <= comb_x_d;
      comb_v_q <= comb_v_d;
    end
  end

  logic [ORDER:0][OUT_WIDTH-1:0] stage_x;
  logic [ORDER:0]                stage_v;

  assign stage_x[0] = comb_x_q;
  assign stage_v[0] = comb_v_q;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .WIDTH (OUT_WIDTH)
    ) u_comb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (stage_v[k]),
      .i_x     (stage_x[k]),
      .o_valid (stage_v[k+1]),
      .o_y     (stage_x[k+1])
    );
  end

  assign o_data  = stage_x[ORDER];
  assign o_valid = stage_v[ORDER];

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator at ORDER=3, DECIM=64: stimulus pushes predicted
// samples, a monitor pops them whenever o_valid rises, plus hand-computed spot values.
module tb_cic_decimator;

  localparam int     W    = 19;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_en;
  logic         i_d;
  logic [W-1:0] o_data;
  logic         o_valid;

  always #5 clk = ~clk;

  cic_decimator dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_d     (i_d),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  typedef struct {
    longint data;
    int     due;
  } exp_t;

  exp_t   expq[$];
  longint got[$];
  int     cyc   = 0;
  int     n_cmp = 0;
  int     n_err = 0;

  longint m_int1, m_int2, m_int3;
  longint h1, h2, h3;
  int     m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle at the falling edge and advance the behavioural model to the
  // state the DUT will reach at the following rising edge.
  task automatic applyStimulus(input bit rst_n, input bit en, input bit d);
    exp_t e;
    i_rst = rst_n;
    i_en  = en;
    i_d   = d;
    if (!rst_n) begin
      m_int1 = 0; m_int2 = 0; m_int3 = 0;
      h1 = 0; h2 = 0; h3 = 0;
      m_cnt = 0;
      expq.delete();
    end else if (en) begin
      m_int3 = m_int3 + m_int2;
      m_int2 = m_int2 + m_int1;
      m_int1 = m_int1 + longint'(d);
      if (m_cnt == 63) begin
        e.data = (m_int3 - 3 * h1 + 3 * h2 - h3) & MASK;
        e.due  = cyc + 4;
        expq.push_back(e);
        h3 = h2; h2 = h1; h1 = m_int3;
      end
      m_cnt = (m_cnt + 1) % 64;
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (expq.size() > 0 && expq[0].due < cyc) begin
        e = expq.pop_front();
        checkOutput("o_valid_missing", 0, longint'(e.due));
      end
      if (o_valid) begin
        if (expq.size() == 0) begin
          checkOutput("o_valid_unexpected", 1, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("o_valid_cycle", longint'(cyc), longint'(e.due));
          checkOutput("o_data_model", longint'(o_data), e.data);
          got.push_back(longint'(o_data));
        end
      end
    end
  end

  initial begin : stimulus
    i_rst = 1'b0;
    i_en  = 1'b0;
    i_d   = 1'b0;
    @(negedge clk);

    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("reset_o_valid", longint'(o_valid), 0);
    checkOutput("reset_o_data", longint'(o_data), 0);

    // Constant ones from reset release, released with i_en high.
    got.delete();
    for (int i = 0; i < 8 * 64; i++) applyStimulus(1, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("ones_count", longint'(got.size()), 8);
    checkOutput("ones_first", got[0], 41664);
    checkOutput("ones_second", got[1], 216384);
    checkOutput("ones_steady3", got[3], 262144);
    checkOutput("ones_steady7", got[7], 262144);

    // Constant zeros from reset: every sample is zero.
    applyStimulus(0, 0, 0);
    got.delete();
    for (int i = 0; i < 6 * 64; i++) applyStimulus(1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("zeros_count", longint'(got.size()), 6);
    for (int i = 0; i < got.size(); i++) checkOutput("zeros_data", got[i], 0);

    got.delete();
    for (int i = 0; i < 5 * 64; i++) applyStimulus(1, 1, (i % 2) == 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("alt_steady", got[4], 131072);

    got.delete();
    for (int i = 0; i < 5 * 64; i++) applyStimulus(1, 1, (i % 4) == 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("quarter_steady", got[4], 65536);

    // Enable only one cycle in three: same samples, three times slower.
    got.delete();
    for (int i = 0; i < 5 * 64 * 3; i++) applyStimulus(1, (i % 3) == 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("slow_en_count", longint'(got.size()), 5);
    checkOutput("slow_en_steady", got[4], 262144);

    // Reset while the frame sits in comb stage 1: that sample must never appear.
    got.delete();
    for (int i = 0; i < 64 && m_cnt != 63; i++) applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("midreset_o_valid", longint'(o_valid), 0);
      checkOutput("midreset_o_data", longint'(o_data), 0);
      applyStimulus(1, 0, 0);
    end
    for (int i = 0; i < 2 * 64; i++) applyStimulus(1, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("midreset_count", longint'(got.size()), 2);
    checkOutput("midreset_first", got[0], 41664);

    // Long all-ones run: upper integrators wrap many times, output must not move.
    got.delete();
    for (int i = 0; i < 40 * 64; i++) applyStimulus(1, 1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0);
    checkOutput("wrap_count", longint'(got.size()), 40);
    for (int i = 0; i < got.size(); i++) checkOutput("wrap_data", got[i], 262144);

    checkOutput("scoreboard_drained", longint'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
